// File: rtl/loader_tile_param.sv
// Tile configuration loader: decodes a tile address into a one-hot target
// strobe plus local address, with valid/ready handshake, bursts and error reporting.
module loader_tile_param #(
    parameter int TILE_ADDR_W  = 10,
    parameter int LOCAL_ADDR_W = 9,
    parameter int DATA_W       = 8,
    parameter int NB_TARGETS   = 2,
    parameter int BURST_LEN_W  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    select_tile,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic                    cfg_burst,
    input  logic [BURST_LEN_W-1:0]  cfg_len,
    input  logic [TILE_ADDR_W-1:0]  address_tile,
    input  logic [DATA_W-1:0]       data_tile,
    input  logic                    tgt_hold,
    output logic [NB_TARGETS-1:0]   tgt_select,
    output logic [LOCAL_ADDR_W-1:0] tgt_address,
    output logic [DATA_W-1:0]       tgt_data,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int T_W = TILE_ADDR_W - LOCAL_ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e                  state_q;
    logic [T_W-1:0]          idx_q;
    logic [LOCAL_ADDR_W-1:0] addr_q;
    logic [BURST_LEN_W-1:0]  left_q;
    logic [NB_TARGETS-1:0]   sel_q;
    logic [LOCAL_ADDR_W-1:0] taddr_q;
    logic [DATA_W-1:0]       tdata_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    err_q;

    logic                    accept_s;
    logic [T_W-1:0]          idx_s;
    logic [LOCAL_ADDR_W-1:0] local_s;
    logic                    single_s;
    logic                    bad_s;

    function automatic logic [NB_TARGETS-1:0] onehot(input logic [T_W-1:0] i);
        logic [NB_TARGETS-1:0] r;
        r = '0;
        for (int k = 0; k < NB_TARGETS; k++) begin
            if (32'(i) == 32'(k)) begin
                r[k] = 1'b1;
            end else begin
                r[k] = 1'b0;
            end
        end
        return r;
    endfunction

    assign cfg_ready   = ~reset & ~tgt_hold;
    assign tgt_select  = sel_q;
    assign tgt_address = taddr_q;
    assign tgt_data    = tdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;

    // First-beat decode: target index, local address, single-vs-burst
    always_comb begin
        accept_s = cfg_valid & cfg_ready;
        idx_s    = address_tile[TILE_ADDR_W-1:LOCAL_ADDR_W];
        local_s  = address_tile[LOCAL_ADDR_W-1:0];
        single_s = ~cfg_burst | (cfg_len <= BURST_LEN_W'(1));
        bad_s    = 32'(idx_s) >= 32'(NB_TARGETS);
    end

    // Transfer FSM with registered write strobe, address/data and status pulses
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            left_q  <= '0;
            sel_q   <= '0;
            taddr_q <= '0;
            tdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sel_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_s && select_tile) begin
                        if (bad_s) begin
                            err_q <= 1'b1;
                        end else begin
                            sel_q   <= onehot(idx_s);
                            taddr_q <= local_s;
                            tdata_q <= data_tile;
                            if (single_s) begin
                                done_q <= 1'b1;
                            end else begin
                                idx_q   <= idx_s;
                                addr_q  <= local_s + LOCAL_ADDR_W'(1);
                                left_q  <= cfg_len - BURST_LEN_W'(1);
                                busy_q  <= 1'b1;
                                state_q <= BURST;
                            end
                        end
                    end
                end
                BURST: begin
                    // Deselect aborts the burst even with a beat pending
                    if (!select_tile) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (accept_s) begin
                        sel_q   <= onehot(idx_q);
                        taddr_q <= addr_q;
                        tdata_q <= data_tile;
                        addr_q  <= addr_q + LOCAL_ADDR_W'(1);
                        left_q  <= left_q - BURST_LEN_W'(1);
                        if (left_q == BURST_LEN_W'(1)) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_loader_tile_param.sv
// Self-checking bench for loader_tile_param (3 targets, 2 index bits):
// transaction-level reference model checked every cycle plus directed literal checks.
module tb_loader_tile_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        select_tile;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_burst;
    logic [7:0]  cfg_len;
    logic [10:0] address_tile;
    logic [7:0]  data_tile;
    logic        tgt_hold;
    logic [2:0]  tgt_select;
    logic [8:0]  tgt_address;
    logic [7:0]  tgt_data;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    loader_tile_param #(
        .TILE_ADDR_W (11),
        .LOCAL_ADDR_W(9),
        .DATA_W      (8),
        .NB_TARGETS  (3),
        .BURST_LEN_W (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .select_tile (select_tile),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_burst   (cfg_burst),
        .cfg_len     (cfg_len),
        .address_tile(address_tile),
        .data_tile   (data_tile),
        .tgt_hold    (tgt_hold),
        .tgt_select  (tgt_select),
        .tgt_address (tgt_address),
        .tgt_data    (tgt_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic drive(input bit v, input bit s, input bit b, input logic [7:0] l,
                         input logic [10:0] a, input logic [7:0] d, input bit h, input bit r);
        @(negedge clock);
        cfg_valid    = v;
        select_tile  = s;
        cfg_burst    = b;
        cfg_len      = l;
        address_tile = a;
        data_tile    = d;
        tgt_hold     = h;
        reset        = r;
    endtask

    task automatic after_edge();
        @(posedge clock);
        #2;
    endtask

    // Reference model: transfer-level bookkeeping, evaluated at each rising edge
    bit  m_burst = 1'b0;
    int  m_tgt, m_addr, m_left;
    int  e_sel, e_addr, e_data;
    bit  e_busy, e_done, e_err, was_reset;

    initial begin
        forever begin
            @(posedge clock);
            check("cfg_ready", {31'd0, cfg_ready}, {31'd0, (!reset && !tgt_hold)});
            was_reset = reset;
            e_done = 1'b0;
            e_err  = 1'b0;
            e_sel  = 0;
            if (reset) begin
                m_burst = 1'b0;
                e_addr  = 0;
                e_data  = 0;
            end else if (!m_burst) begin
                if (cfg_valid && !tgt_hold && select_tile) begin
                    int idx, loc, n;
                    idx = int'(address_tile) / 512;
                    loc = int'(address_tile) % 512;
                    n   = (cfg_len == 8'd0) ? 1 : int'(cfg_len);
                    if (idx >= 3) begin
                        e_err = 1'b1;
                    end else begin
                        e_sel  = 1 << idx;
                        e_addr = loc;
                        e_data = int'(data_tile);
                        if (!cfg_burst || n == 1) begin
                            e_done = 1'b1;
                        end else begin
                            m_burst = 1'b1;
                            m_tgt   = idx;
                            m_addr  = (loc + 1) % 512;
                            m_left  = n - 1;
                        end
                    end
                end
            end else begin
                if (!select_tile) begin
                    e_err   = 1'b1;
                    m_burst = 1'b0;
                end else if (cfg_valid && !tgt_hold) begin
                    e_sel  = 1 << m_tgt;
                    e_addr = m_addr;
                    e_data = int'(data_tile);
                    m_addr = (m_addr + 1) % 512;
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        e_done  = 1'b1;
                        m_burst = 1'b0;
                    end
                end
            end
            e_busy = m_burst;
            #1;
            check("tgt_select", {29'd0, tgt_select}, 32'(e_sel));
            check("busy", {31'd0, busy}, {31'd0, e_busy});
            check("done", {31'd0, done}, {31'd0, e_done});
            check("err", {31'd0, err}, {31'd0, e_err});
            if (e_sel != 0 || was_reset) begin
                check("tgt_address", {23'd0, tgt_address}, 32'(e_addr));
                check("tgt_data", {24'd0, tgt_data}, 32'(e_data));
            end
        end
    end

    logic [8:0] exp_a [4];

    initial begin
        reset = 1'b1; select_tile = 1'b0; cfg_valid = 1'b0; cfg_burst = 1'b0;
        cfg_len = 8'd0; address_tile = 11'd0; data_tile = 8'd0; tgt_hold = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
        check("rst_outputs", {19'd0, tgt_select, busy, done, err, tgt_address[0], tgt_data[0], 5'd0}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 8'd0, 11'd0, 8'd0, 1'b0, 1'b0);

        // Single write to target 1, local 0x005
        drive(1'b1, 1'b1, 1'b0, 8'd0, 11'h205, 8'hA5, 1'b0, 1'b0);
        after_edge();
        check("single_sel", {29'd0, tgt_select}, 32'h2);
        check("single_addr", {23'd0, tgt_address}, 32'h005);
        check("single_data", {24'd0, tgt_data}, 32'hA5);
        check("single_done", {31'd0, done}, 32'd1);

        // Burst of 4 across a 0x0FF->0x100 boundary
        exp_a[0] = 9'h0FE; exp_a[1] = 9'h0FF; exp_a[2] = 9'h100; exp_a[3] = 9'h101;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 1'b1, 8'd4, 11'h0FE, 8'(i + 1), 1'b0, 1'b0);
            after_edge();
            check("burst_sel", {29'd0, tgt_select}, 32'h1);
            check("burst_addr", {23'd0, tgt_address}, {23'd0, exp_a[i]});
            check("burst_done", {31'd0, done}, (i == 3) ? 32'd1 : 32'd0);
            check("burst_busy", {31'd0, busy}, (i < 3) ? 32'd1 : 32'd0);
        end

        // Wrap from 0x1FF to 0x000 within target 0
        exp_a[0] = 9'h1FF; exp_a[1] = 9'h000; exp_a[2] = 9'h001;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 8'd3, 11'h1FF, 8'h30, 1'b0, 1'b0);
            after_edge();
            check("wrap_sel", {29'd0, tgt_select}, 32'h1);
            check("wrap_addr", {23'd0, tgt_address}, {23'd0, exp_a[i]});
        end

        // Index 3 does not exist
        drive(1'b1, 1'b1, 1'b1, 8'd4, 11'h605, 8'h11, 1'b0, 1'b0);
        after_edge();
        check("badidx_err", {31'd0, err}, 32'd1);
        check("badidx_sel", {29'd0, tgt_select}, 32'd0);
        check("badidx_busy", {31'd0, busy}, 32'd0);

        // Back-pressure mid-burst, then resume
        drive(1'b1, 1'b1, 1'b1, 8'd4, 11'h210, 8'h50, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 8'd4, 11'h000, 8'h60, 1'b1, 1'b0);
            #1;
            check("hold_ready", {31'd0, cfg_ready}, 32'd0);
            after_edge();
            check("hold_sel", {29'd0, tgt_select}, 32'd0);
            check("hold_busy", {31'd0, busy}, 32'd1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 8'd4, 11'h000, 8'(8'h51 + i), 1'b0, 1'b0);
            after_edge();
            check("resume_addr", {23'd0, tgt_address}, 32'(9'h011 + i));
            check("resume_sel", {29'd0, tgt_select}, 32'h2);
        end
        check("resume_done", {31'd0, done}, 32'd1);

        // Abort by deselect on 2nd beat
        drive(1'b1, 1'b1, 1'b1, 8'd4, 11'h020, 8'h70, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 8'd4, 11'h020, 8'h71, 1'b0, 1'b0);
        after_edge();
        check("abort_err", {31'd0, err}, 32'd1);
        check("abort_sel", {29'd0, tgt_select}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);

        // Reset on 2nd beat
        drive(1'b1, 1'b1, 1'b1, 8'd4, 11'h020, 8'h80, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'd4, 11'h020, 8'h81, 1'b0, 1'b1);
        after_edge();
        check("rstmid_outs", {24'd0, tgt_select, busy, done, err, 2'd0}, 32'd0);
        check("rstmid_addr", {23'd0, tgt_address}, 32'd0);
        check("rstmid_data", {24'd0, tgt_data}, 32'd0);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 29) != 0, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6)),
                  11'($urandom), 8'($urandom), $urandom_range(0, 4) == 0,
                  $urandom_range(0, 249) == 0);
        end
        drive(1'b0, 1'b1, 1'b0, 8'd0, 11'd0, 8'd0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/loader_tile_param.md
# loader_tile_param

Parametrised configuration loader for one FPGA tile; successor to the fixed 10-bit/8-bit single-target tile loader. Sits between the array-level configuration bus and the tile's configurable targets (switch box, clusters). It decodes a tile address into a one-hot target select plus a local address. It adds valid/ready handshaking, target back-pressure, auto-incrementing burst writes, and error/done reporting.

## Interface
- TILE_ADDR_W, 10, width of incoming tile address
- LOCAL_ADDR_W, 9, width of address forwarded to a target; T_W = TILE_ADDR_W-LOCAL_ADDR_W index bits, 2^T_W >= NB_TARGETS
- DATA_W, 8, configuration data width
- NB_TARGETS, 2, number of configurable targets in the tile
- BURST_LEN_W, 8, width of burst length field

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- select_tile  in  1  tile selected by array-level decoder
- cfg_valid  in  1  beat offered
- cfg_ready  out  1  beat accepted when cfg_valid & cfg_ready
- cfg_burst  in  1  sampled on first beat: 1 = burst, 0 = single write
- cfg_len  in  BURST_LEN_W  beats in burst, sampled on first beat; 0 treated as 1
- address_tile  in  TILE_ADDR_W  {target index, local address}; sampled on first beat only
- data_tile  in  DATA_W  configuration data
- tgt_hold  in  1  any target unable to accept a write
- tgt_select  out  NB_TARGETS  one-hot write strobe, one cycle per write
- tgt_address  out  LOCAL_ADDR_W  local address of current write
- tgt_data  out  DATA_W  data of current write
- busy  out  1  high in BURST
- done  out  1  one-cycle pulse on final write of a single/burst
- err  out  1  one-cycle pulse: bad target index or aborted burst

## Operation
- States: IDLE, BURST.
- cfg_ready = ~reset & ~tgt_hold, combinational; no beat is accepted while tgt_hold=1.
- IDLE, accepted beat with select_tile=1: idx = address_tile[TILE_ADDR_W-1:LOCAL_ADDR_W].
  - idx >= NB_TARGETS: no write, err pulse, stay IDLE (burst request dropped).
  - cfg_burst=0 or effective length 1: write (idx, local addr, data), done pulse, stay IDLE.
  - cfg_burst=1, effective length N>1: write first beat, latch idx, base = local addr+1, beats_left = N-1, go BURST.
- IDLE, cfg_valid with select_tile=0: ignored, no output.
- BURST: each accepted beat writes data_tile to latched idx at running address; address_tile, cfg_burst and cfg_len are ignored. Address then increments modulo 2^LOCAL_ADDR_W (wrap, same target) and beats_left decrements. The beat with beats_left=1 gives done pulse, busy drops, return to IDLE.
- Abort: select_tile=0 in any BURST cycle -> no write that cycle, err pulse, IDLE. This holds even if cfg_valid is high, and abort wins over a simultaneous last beat.
- tgt_hold stalls in BURST without changing state, counter or address.

## Timing
- All outputs except cfg_ready are registered. Write/done/err appear the cycle after the accepting edge, which is 1-cycle latency. tgt_select is high for exactly one cycle per write.
- tgt_address/tgt_data hold their last value when no write occurs and are valid only when tgt_select != 0.
- Back-to-back beats sustain one write per cycle, including IDLE->BURST and BURST->IDLE->next transfer.
- Reset values: tgt_select=0, tgt_address=0, tgt_data=0, busy=0, done=0, err=0, state IDLE, cfg_ready=0 while reset=1.
- Reset mid-burst: next cycle IDLE with all outputs at reset values. No done or err is generated, and remaining beats are discarded.

## Test plan
- Single write: address_tile=10'h205, data 8'hA5, burst=0 -> next cycle tgt_select=2'b10, tgt_address=9'h005, tgt_data=A5, done=1.
- Burst len 4 at 10'h0FE, data 1..4 -> tgt_select=01 for four cycles, addresses 0FE,0FF,100,101, done on 4th, busy high between.
- Wrap: burst len 3 at local 9'h1FF -> addresses 1FF,000,001, target unchanged.
- Bad index (NB_TARGETS=3, T_W=2, address index 3) -> err pulse, tgt_select stays 0, remains IDLE.
- Back-pressure: tgt_hold=1 for 3 cycles mid-burst -> cfg_ready=0, no writes, no address advance; the burst resumes intact.
- Abort/reset: select_tile=0 on 2nd of 4 beats -> err, no write, IDLE. Repeat with reset on 2nd beat -> no done/err, all outputs 0.
